revaluate_engine: RTL and testbench

//  Responder end of the revaluate start/done handshake. It sits under the top controller,

---
 rtl/revaluate_engine.sv | 153 +++++++++++++++
 tb/tb_revaluate_engine.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/revaluate_engine.sv
// Theta-style in-place pass over a 5x5 lane state held in an external single-port memory.
// Lane (x,y) lives at address 5*y+x. A start pulse runs one full column-parity gather
// followed by a read/modify/write sweep, then a one-cycle done pulse.
module revaluate_engine #(
  parameter int unsigned W   = 64,
  parameter int unsigned ROT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         revaluate_start,
  output logic         revaluate_done,
  output logic         busy,
  output logic [4:0]   mem_addr,
  output logic         mem_rd,
  output logic         mem_wr,
  input  logic [W-1:0] mem_rdata,
  output logic [W-1:0] mem_wdata
);

  localparam int unsigned ROT_M     = ROT % W;
  localparam int unsigned NUM_LANES = 25;
  localparam int unsigned LAST_LANE = NUM_LANES - 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PARITY   = 3'd1,
    S_PAR_LAST = 3'd2,
    S_UPD_RD   = 3'd3,
    S_UPD_WR   = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [2:0]     xi_q, xi_d;
  logic [W-1:0]   c_q [5];
  logic [W-1:0]   c_d [5];
  logic [2:0]     xm1;
  logic [2:0]     xp1;

  // Left rotate by the fixed amount; a zero rotate must not shift by the full width.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] v);
    if (ROT_M == 0) return v;
    return (v << ROT_M) | (v >> (W - ROT_M));
  endfunction

  // Column neighbours of the current lane, modulo 5 without a divider.
  assign xm1 = (xi_q == 3'd0) ? 3'd4 : xi_q - 3'd1;
  assign xp1 = (xi_q == 3'd4) ? 3'd0 : xi_q + 3'd1;

  // State, lane counter, column counter and parity accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      xi_q    <= '0;
      for (int i = 0; i < 5; i++) c_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xi_q    <= xi_d;
      for (int i = 0; i < 5; i++) c_q[i] <= c_d[i];
    end
  end

  // Next-state, counter and parity-accumulate logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xi_d    = xi_q;
    for (int i = 0; i < 5; i++) c_d[i] = c_q[i];
    unique case (state_q)
      S_IDLE: begin
        if (revaluate_start) begin
          state_d = S_PARITY;
          cnt_d   = '0;
          xi_d    = '0;
          for (int i = 0; i < 5; i++) c_d[i] = '0;
        end
      end
      S_PARITY: begin
        // Read data lags the address by one cycle, so it belongs to column xi-1.
        if (cnt_q != 5'd0) c_d[xm1] = c_q[xm1] ^ mem_rdata;
        cnt_d = cnt_q + 5'd1;
        xi_d  = xp1;
        if (cnt_q == 5'(LAST_LANE)) state_d = S_PAR_LAST;
      end
      S_PAR_LAST: begin
        // Lane 24 sits in column 4.
        c_d[4]  = c_q[4] ^ mem_rdata;
        cnt_d   = '0;
        xi_d    = '0;
        state_d = S_UPD_RD;
      end
      S_UPD_RD: begin
        state_d = S_UPD_WR;
      end
      S_UPD_WR: begin
        if (cnt_q == 5'(LAST_LANE)) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 5'd1;
          xi_d    = xp1;
          state_d = S_UPD_RD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore-decoded strobes; write data is formed from the lane just read.
  always_comb begin
    revaluate_done = 1'b0;
    busy           = 1'b0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    unique case (state_q)
      S_PARITY: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = cnt_q;
      end
      S_PAR_LAST: begin
        busy = 1'b1;
      end
      S_UPD_RD: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = cnt_q;
      end
      S_UPD_WR: begin
        busy      = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = mem_rdata ^ c_q[xm1] ^ rotl(c_q[xp1]);
      end
      S_DONE: begin
        busy           = 1'b1;
        revaluate_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_revaluate_engine.sv
// Bench for revaluate_engine: two instances (ROT=1 and ROT=13) each on their own lane memory.
// Expected writes and done cycles are queued at start time and compared as they appear.
module tb_revaluate_engine;

  typedef logic [63:0] lanes_t [25];
  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        dne   [2];
  logic        busy  [2];
  logic [4:0]  addr  [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [63:0] rdata [2];
  logic [63:0] wdata [2];
  logic [63:0] mem   [2][25];

  int unsigned cyc = 0;
  int unsigned n_run = 0;
  int unsigned n_fail = 0;
  int unsigned rdn [2];
  int unsigned wrn [2];
  int unsigned donen [2];
  wr_t         q0 [$];
  wr_t         q1 [$];
  int unsigned dq0 [$];
  int unsigned dq1 [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    revaluate_engine #(.W(64), .ROT((g == 0) ? 1 : 13)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .revaluate_start (start),
      .revaluate_done  (dne[g]),
      .busy            (busy[g]),
      .mem_addr        (addr[g]),
      .mem_rd          (rd[g]),
      .mem_wr          (wr[g]),
      .mem_rdata       (rdata[g]),
      .mem_wdata       (wdata[g])
    );
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port memories: write lands at the edge, read data one cycle later.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr[i] === 1'b1 && addr[i] < 5'd25) mem[i][addr[i]] = wdata[i];
      if (rd[i] === 1'b1 && addr[i] < 5'd25) rdata[i] <= mem[i][addr[i]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rotl64(input logic [63:0] v, input int unsigned r);
    int unsigned s;
    s = r % 64;
    if (s == 0) return v;
    return (v << s) | (v >> (64 - s));
  endfunction

  function automatic lanes_t theta(input lanes_t a, input int unsigned rot);
    logic [63:0] c [5];
    lanes_t r;
    for (int x = 0; x < 5; x++) begin
      c[x] = '0;
      for (int y = 0; y < 5; y++) c[x] ^= a[5*y+x];
    end
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[5*y+x] = a[5*y+x] ^ c[(x+4)%5] ^ rotl64(c[(x+1)%5], rot);
    return r;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      wr_t e;
      int unsigned dc;
      if (rd[i] === 1'b1 && wr[i] === 1'b1) check($sformatf("rd_wr_excl%0d", i), 64'd1, 64'd0);
      if ((rd[i] === 1'b1 || wr[i] === 1'b1) && addr[i] > 5'd24)
        check($sformatf("addr_range%0d", i), 64'(addr[i]), 64'd24);
      if (rd[i] === 1'b1) rdn[i]++;
      if (wr[i] === 1'b1) begin
        wrn[i]++;
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          check($sformatf("unexp_write%0d", i), 64'(addr[i]), 64'hFFFF);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("wr_addr%0d", i), 64'(addr[i]), 64'(e.addr));
          check($sformatf("wr_data%0d_lane%0d", i, e.addr), wdata[i], e.data);
        end
      end
      if (dne[i] === 1'b1) begin
        donen[i]++;
        if ((i == 0 && dq0.size() == 0) || (i == 1 && dq1.size() == 0)) begin
          check($sformatf("unexp_done%0d", i), 64'(cyc), 64'hFFFF);
        end else begin
          dc = (i == 0) ? dq0.pop_front() : dq1.pop_front();
          check($sformatf("done_cycle%0d", i), 64'(cyc), 64'(dc));
        end
      end
    end
  end

  // Queue the expected writes and done cycle for a pass started in the current cycle.
  task automatic push_pass();
    lanes_t a, e;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 25; k++) a[k] = mem[i][k];
      e = theta(a, (i == 0) ? 1 : 13);
      for (int k = 0; k < 25; k++) begin
        if (i == 0) q0.push_back('{addr: 5'(k), data: e[k]});
        else        q1.push_back('{addr: 5'(k), data: e[k]});
      end
      rdn[i] = 0;
      wrn[i] = 0;
    end
    dq0.push_back(cyc + 77);
    dq1.push_back(cyc + 77);
  endtask

  // Called on a falling edge; start is high for exactly the current cycle.
  task automatic pulse_start(input bit counted);
    if (counted) push_pass();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned tgt, input string tag);
    int unsigned n;
    n = 0;
    while (donen[0] < tgt && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(donen[0]), 64'(tgt));
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_busy%0d", tag, i), 64'(busy[i]), 64'd0);
      check($sformatf("%s_done%0d", tag, i), 64'(dne[i]), 64'd0);
      check($sformatf("%s_rd%0d", tag, i), 64'(rd[i]), 64'd0);
      check($sformatf("%s_wr%0d", tag, i), 64'(wr[i]), 64'd0);
      check($sformatf("%s_addr%0d", tag, i), 64'(addr[i]), 64'd0);
      check($sformatf("%s_wdata%0d", tag, i), wdata[i], 64'd0);
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 25; k++) mem[i][k] = {$urandom, $urandom};
  endtask

  task automatic check_counts(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_reads%0d", tag, i), 64'(rdn[i]), 64'd50);
      check($sformatf("%s_writes%0d", tag, i), 64'(wrn[i]), 64'd25);
    end
  endtask

  initial begin
    int unsigned t;
    logic [63:0] exp1;
    logic [63:0] exp13;
    for (int i = 0; i < 2; i++) begin
      rdn[i] = 0; wrn[i] = 0; donen[i] = 0; rdata[i] = '0;
      for (int k = 0; k < 25; k++) mem[i][k] = '0;
    end

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // All-zero memory: busy exactly T+1..T+77, done at T+77, zero lanes written
    t = cyc;
    pulse_start(1'b1);
    for (int c = 1; c <= 78; c++) begin
      check($sformatf("busy0_T+%0d", c), 64'(busy[0]), (c <= 77) ? 64'd1 : 64'd0);
      check($sformatf("busy1_T+%0d", c), 64'(busy[1]), (c <= 77) ? 64'd1 : 64'd0);
      @(negedge clk);
    end
    check("zero_done_count", 64'(donen[0]), 64'd1);
    check_counts("zero");
    for (int k = 0; k < 25; k++) check($sformatf("zero_lane%0d", k), mem[0][k], 64'd0);

    // Single bit in lane 0
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 25; k++) mem[i][k] = (k == 0) ? 64'h1 : 64'h0;
    pulse_start(1'b1);
    wait_done(2, "single_done");
    for (int k = 0; k < 25; k++) begin
      exp1  = 64'h0;
      exp13 = 64'h0;
      if (k % 5 == 1) begin exp1 = 64'h1; exp13 = 64'h1; end
      if (k % 5 == 4) begin exp1 = 64'h2; exp13 = 64'h2000; end
      if (k == 0)     begin exp1 = 64'h1; exp13 = 64'h1; end
      check($sformatf("single_r1_lane%0d", k), mem[0][k], exp1);
      check($sformatf("single_r13_lane%0d", k), mem[1][k], exp13);
    end

    // Random states
    for (int r = 0; r < 2; r++) begin
      load_random();
      pulse_start(1'b1);
      wait_done(3 + r, "rand_done");
      check_counts("rand");
    end

    // Extra start pulses while busy and in the done cycle are ignored
    load_random();
    t = cyc;
    pulse_start(1'b1);
    while (cyc < t + 5) @(negedge clk);
    pulse_start(1'b0);
    while (cyc < t + 77) @(negedge clk);
    pulse_start(1'b0);
    repeat (100) @(negedge clk);
    check("ignore_done_count", 64'(donen[0]), 64'd5);
    check("ignore_busy", 64'(busy[0]), 64'd0);
    check("ignore_pending", 64'(q0.size() + q1.size()), 64'd0);
    check_counts("ignore");

    // Reset mid-run aborts; a fresh start then runs a full pass
    load_random();
    t = cyc;
    pulse_start(1'b1);
    while (cyc < t + 40) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q0.delete(); q1.delete(); dq0.delete(); dq1.delete();
    @(negedge clk);
    check("midreset_cycle", 64'(cyc), 64'(t + 41));
    check_idle_outputs("midreset");
    rst = 1'b0;
    @(negedge clk);
    pulse_start(1'b1);
    wait_done(6, "after_reset_done");
    check_counts("after_reset");

    // Back-to-back passes: start again in the cycle after done
    t = cyc;
    pulse_start(1'b1);
    while (cyc < t + 78) @(negedge clk);
    check("b2b_first_done", 64'(donen[0]), 64'd7);
    pulse_start(1'b1);
    wait_done(8, "b2b_second_done");
    check_counts("b2b");

    repeat (5) @(negedge clk);
    check("final_pending_writes", 64'(q0.size() + q1.size()), 64'd0);
    check("final_pending_done", 64'(dq0.size() + dq1.size()), 64'd0);
    check("final_done_r13", 64'(donen[1]), 64'(donen[0]));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
